// File: rtl/mul_pkg.sv
// Shared constants and types for the radix-4 Booth sequential multiplier.
package mul_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ITERS = WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_PM   = 3'd1,
    SEL_P2M  = 3'd2,
    SEL_NM   = 3'd3,
    SEL_N2M  = 3'd4
  } booth_sel_t;

  // Radix-4 Booth recoding of {Q[1:0], q_m1}
  function automatic booth_sel_t booth_decode(input logic [2:0] bits);
    booth_sel_t sel;
    case (bits)
      3'b001, 3'b010: sel = SEL_PM;
      3'b011:         sel = SEL_P2M;
      3'b100:         sel = SEL_N2M;
      3'b101, 3'b110: sel = SEL_NM;
      default:        sel = SEL_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_r4_step.sv
// One radix-4 Booth iteration: add the selected multiple of M to A, then
// arithmetic-shift {A, Q, q_m1} right by two.
module booth_r4_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH+1:0] a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);
  import mul_pkg::*;

  localparam int unsigned AW = WIDTH + 2;

  logic [AW-1:0] m_ext;
  logic [AW-1:0] addend;
  logic [AW-1:0] sum;
  booth_sel_t    sel;

  always_comb begin
    m_ext  = {{2{m[WIDTH-1]}}, m};
    sel    = booth_decode({q[1:0], q_m1});
    addend = '0;
    case (sel)
      SEL_PM:  addend = m_ext;
      SEL_P2M: addend = m_ext << 1;
      SEL_NM:  addend = -m_ext;
      SEL_N2M: addend = -(m_ext << 1);
      default: addend = '0;
    endcase
    sum       = a + addend;
    a_next    = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_next    = {sum[1:0], q[WIDTH-1:2]};
    q_m1_next = q[1];
  end

endmodule

// File: rtl/booth_seq_mul_ctrl.sv
// Multi-cycle signed radix-4 Booth multiplier: FSM, iteration counter,
// operand/accumulator registers and the HI/LO result registers.
module booth_seq_mul_ctrl #(
  parameter int unsigned WIDTH = mul_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mul_pkg::state_t;
  import mul_pkg::IDLE;
  import mul_pkg::RUN;
  import mul_pkg::DONE;

  localparam int unsigned ITERS = WIDTH / 2;
  localparam int unsigned AW    = WIDTH + 2;
  localparam int unsigned CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] m_reg, q_reg, q_step;
  logic [AW-1:0]    a_reg, a_step;
  logic             qm1_reg, qm1_step;
  logic             load, iter, finish;

  booth_r4_step #(.WIDTH(WIDTH)) u_step (
    .a         (a_reg),
    .q         (q_reg),
    .q_m1      (qm1_reg),
    .m         (m_reg),
    .a_next    (a_step),
    .q_next    (q_step),
    .q_m1_next (qm1_step)
  );

  // Next-state and datapath control; abort always beats a same-cycle start
  always_comb begin
    state_next = state;
    load       = 1'b0;
    iter       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          iter = 1'b1;
          if (count == LAST) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (start && !abort) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // busy/done are decoded from the next state so they line up with the state itself
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      m_reg   <= '0;
      q_reg   <= '0;
      a_reg   <= '0;
      qm1_reg <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      if (load) begin
        m_reg   <= multiplicand;
        q_reg   <= multiplier;
        a_reg   <= '0;
        qm1_reg <= 1'b0;
        count   <= '0;
      end else if (iter) begin
        a_reg   <= a_step;
        q_reg   <= q_step;
        qm1_reg <= qm1_step;
        count   <= count + CW'(1);
      end
      if (finish) begin
        hi <= a_step[WIDTH-1:0];
        lo <= q_step;
      end
    end
  end

endmodule

// File: tb/tb_booth_seq_mul_ctrl.sv
// Self-checking bench for booth_seq_mul_ctrl: cycle-level behavioural model
// plus directed literal expectations and randomized operands.
module tb_booth_seq_mul_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  int dut_dones = 0;
  int mdl_dones = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  booth_seq_mul_ctrl #(.WIDTH(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: an accepted request runs 16 cycles, then one done cycle
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_left = 0;
  logic [63:0] m_prod = '0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_prod <= '0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_busy) begin
      m_done <= 1'b0;
      if (abort) begin
        m_busy <= 1'b0;
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_hi   <= m_prod[63:32];
        m_lo   <= m_prod[31:0];
      end else begin
        m_left <= m_left - 1;
      end
    end else begin
      m_done <= 1'b0;
      if (start && !abort) begin
        m_busy <= 1'b1;
        m_left <= 16;
        m_prod <= longint'($signed(multiplicand)) * longint'($signed(multiplier));
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (done) dut_dones++;
    if (m_done) mdl_dones++;
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic issue(input logic [31:0] m, input logic [31:0] q);
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(negedge clock);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic op(input string name, input logic [31:0] m, input logic [31:0] q,
                    input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    issue(m, q);
    wait_done(lat);
    check({name, " latency"}, 64'(lat), 64'd17);
    check({name, " hi"}, 64'(hi), 64'(exp_hi));
    check({name, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h8000_0000;
      1:       v = 32'h7FFF_FFFF;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h0000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int saw;
    logic [31:0] rm, rq;
    logic [63:0] rp;

    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    op("t1", 32'd123, 32'd456, 32'h0000_0000, 32'h0000_DB18);
    @(negedge clock);

    op("t2a", 32'hFFFF_FFC9, 32'd13, 32'hFFFF_FFFF, 32'hFFFF_FD35);
    op("t2b", 32'h7FFF_FFFF, 32'd2, 32'h0000_0000, 32'hFFFF_FFFE);
    @(negedge clock);

    op("t3", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    @(negedge clock);
    op("t4", 32'hFFFF_FE44, 32'hFFFF_FEB3, 32'h0000_0000, 32'h0002_418C);
    @(negedge clock);
    op("t5", 32'd789, 32'hFFFF_FEBF, 32'hFFFF_FFFF, 32'hFFFC_22AB);
    @(negedge clock);

    // Abort at N+6 of a 5*7 operation
    issue(32'd5, 32'd7);
    repeat (5) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    saw = dut_dones;
    repeat (30) @(negedge clock);
    check("abort no done", 64'(dut_dones), 64'(saw));
    check("abort hi", 64'(hi), 64'hFFFF_FFFF);
    check("abort lo", 64'(lo), 64'hFFFC_22AB);

    // start during RUN is ignored
    issue(32'd3, 32'd4);
    repeat (3) @(negedge clock);
    start = 1'b1;
    multiplicand = 32'd100;
    multiplier = 32'd100;
    @(negedge clock);
    start = 1'b0;
    saw = 0;
    while (!done && saw < 40) begin
      @(negedge clock);
      saw++;
    end
    check("run start hi", 64'(hi), 64'd0);
    check("run start lo", 64'(lo), 64'd12);
    @(negedge clock);
    repeat (3) @(negedge clock);
    check("run start not queued", 64'(busy), 64'd0);

    // start+abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    multiplicand = 32'd9;
    multiplier = 32'd9;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    check("start+abort busy", 64'(busy), 64'd0);
    saw = dut_dones;
    repeat (20) @(negedge clock);
    check("start+abort no done", 64'(dut_dones), 64'(saw));

    // Randomized operands, sometimes issued back-to-back from DONE
    for (int i = 0; i < 25; i++) begin
      rm = pick();
      rq = pick();
      rp = longint'($signed(rm)) * longint'($signed(rq));
      op("rnd", rm, rq, rp[63:32], rp[31:0]);
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end
    @(negedge clock);

    // Asynchronous reset mid-operation
    op("pre", 32'd3, 32'd5, 32'd0, 32'd15);
    @(negedge clock);
    issue(32'h0000_1234, 32'h0000_5678);
    repeat (7) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async busy", 64'(busy), 64'd0);
    check("async done", 64'(done), 64'd0);
    check("async hi", 64'(hi), 64'd0);
    check("async lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    op("zero", 32'd0, 32'd12345, 32'd0, 32'd0);
    repeat (3) @(negedge clock);

    check("done count", 64'(dut_dones), 64'(mdl_dones));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
